// File: rtl/big_adder_pkg.sv
// Shared constants and configuration check for the pipelined big adder.
package big_adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;
  localparam int DEF_NSEG  = DEF_WIDTH / DEF_SEG_W;

  function automatic bit cfg_ok(input int width, input int seg_w);
    return (seg_w >= 1) && (seg_w <= width) && ((width % seg_w) == 0);
  endfunction
endpackage

// File: rtl/big_adder_seg.sv
// SEG_W-bit combinational ripple slice; cv[j] is the carry out of bit j.
module big_adder_seg
  import big_adder_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic [SEG_W-1:0] cv
);
  logic [SEG_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int j = 0; j < SEG_W; j++) begin
      s[j]   = a[j] ^ b[j] ^ c[j];
      c[j+1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
    end
  end

  assign cv = c[SEG_W:1];
  assign co = c[SEG_W];
endmodule

// File: rtl/big_adder_pipe.sv
// Pipelined add/subtract, one SEG_W-bit ripple segment per stage, valid/ready with global stall.
// Define BIG_ADDER_CARRY_VEC_EN to export the per-bit carry vector aligned with so.
module big_adder_pipe
  import big_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] so,
  output logic             c_out,
  output logic             ovf_out
`ifdef BIG_ADDER_CARRY_VEC_EN
  ,
  output logic [WIDTH-1:0] carry_vec
`endif
);
  localparam int NSEG = WIDTH / SEG_W;

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
    $error("big_adder_pipe: WIDTH must be a positive multiple of SEG_W");
  end

  logic                         adv;
  logic [NSEG-1:0]              vld_pipe;
  logic [NSEG-1:0][WIDTH-1:0]   a_q, b_q, s_q, a_d, b_d, s_d;
  logic [NSEG-1:0]              c_q, c_d;
  logic                         ovf_q, ovf_d;
`ifdef BIG_ADDER_CARRY_VEC_EN
  logic [NSEG-1:0][WIDTH-1:0]   cv_q, cv_d;
`endif

  assign out_valid = vld_pipe[NSEG-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO = k * SEG_W;
    // Operand bits at and below this segment are consumed here; only higher bits travel on.
    localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << ((k + 1) * SEG_W);

    logic [WIDTH-1:0] sa, sb, ss;
    logic             sc;
    logic [SEG_W-1:0] seg_s, seg_cv;
    logic             seg_co;
`ifdef BIG_ADDER_CARRY_VEC_EN
    logic [WIDTH-1:0] scv;
`endif

    if (k == 0) begin : g_first
      assign sa = a_in;
      assign sb = b_in ^ {WIDTH{sub_in}};
      assign ss = '0;
      assign sc = sub_in | c_in;
`ifdef BIG_ADDER_CARRY_VEC_EN
      assign scv = '0;
`endif
    end else begin : g_next
      assign sa = a_q[k-1];
      assign sb = b_q[k-1];
      assign ss = s_q[k-1];
      assign sc = c_q[k-1];
`ifdef BIG_ADDER_CARRY_VEC_EN
      assign scv = cv_q[k-1];
`endif
    end

    big_adder_seg #(.SEG_W(SEG_W)) u_seg (
      .a  (sa[LO +: SEG_W]),
      .b  (sb[LO +: SEG_W]),
      .ci (sc),
      .s  (seg_s),
      .co (seg_co),
      .cv (seg_cv)
    );

    // Bits above the resolved range are still zero, so OR-ing in the new segment is exact.
    assign a_d[k] = sa & HI_MASK;
    assign b_d[k] = sb & HI_MASK;
    assign s_d[k] = ss | (WIDTH'(seg_s) << LO);
    assign c_d[k] = seg_co;
`ifdef BIG_ADDER_CARRY_VEC_EN
    assign cv_d[k] = scv | (WIDTH'(seg_cv) << LO);
`else
    logic unused_cv;
    assign unused_cv = ^seg_cv;
`endif

    if (k == NSEG - 1) begin : g_last
      // a^b^s at the MSB recovers the carry into it.
      assign ovf_d = sa[WIDTH-1] ^ sb[WIDTH-1] ^ seg_s[SEG_W-1] ^ seg_co;
    end
  end

  // The last stage has no further segments, so its operand copy is dead.
  logic unused_tail;
  assign unused_tail = ^{a_q[NSEG-1], b_q[NSEG-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
`ifdef BIG_ADDER_CARRY_VEC_EN
      cv_q     <= '0;
`endif
    end else if (adv) begin
      for (int k = NSEG - 1; k > 0; k--) vld_pipe[k] <= vld_pipe[k-1];
      vld_pipe[0] <= in_valid;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
`ifdef BIG_ADDER_CARRY_VEC_EN
      cv_q        <= cv_d;
`endif
    end
  end

  assign so      = s_q[NSEG-1];
  assign c_out   = c_q[NSEG-1];
  assign ovf_out = ovf_q;
`ifdef BIG_ADDER_CARRY_VEC_EN
  assign carry_vec = cv_q[NSEG-1];
`endif
endmodule

// File: tb/tb_big_adder_pipe.sv
// Scoreboard bench for big_adder_pipe: driver pushes model results on accept, monitor pops on output.
module tb_big_adder_pipe #(
  parameter int W   = 16,
  parameter int SEG = 4
);
  localparam int NS = W / SEG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, sub_in = 1'b0, c_in = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, c_out, ovf_out;
  logic [W-1:0] a_in = '0, b_in = '0, so;
`ifdef BIG_ADDER_CARRY_VEC_EN
  logic [W-1:0] carry_vec;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    logic [W-1:0] cv;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0, checks = 0;

  big_adder_pipe #(.WIDTH(W), .SEG_W(SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub_in(sub_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .so(so), .c_out(c_out), .ovf_out(ovf_out)
`ifdef BIG_ADDER_CARRY_VEC_EN
    , .carry_vec(carry_vec)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] trunc(input logic [31:0] v);
    return v[W-1:0];
  endfunction

  // Reference: plain integer arithmetic on the spec's rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic ci);
    exp_t         e;
    logic [W-1:0] bb;
    logic         cin;
    logic [W:0]   sum;
    logic [W+1:0] one, m, lo;
    longint       sa, sbv, r, hi_lim, lo_lim;
    bb  = sub ? ~b : b;
    cin = sub ? 1'b1 : ci;
    sum = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
    e.s = sum[W-1:0];
    e.c = sum[W];
    sa     = longint'($signed(a));
    sbv    = longint'($signed(b));
    r      = sub ? (sa - sbv) : (sa + sbv + longint'(ci));
    hi_lim = (longint'(1) << (W - 1)) - 1;
    lo_lim = -(longint'(1) << (W - 1));
    e.ovf  = (r > hi_lim) || (r < lo_lim);
    one = 1;
    for (int i = 0; i < W; i++) begin
      m  = (one << (i + 1)) - one;
      lo = ({2'b00, a} & m) + ({2'b00, bb} & m) + (W+2)'(cin);
      e.cv[i] = lo[i+1];
    end
    return e;
  endfunction

  // Monitor: samples on the falling edge, so handshakes seen here take effect at the next rise.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_so = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(out_valid), 64'(1));
        chk("stall_so_hold", 64'(so), 64'(prev_so));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 64'(sb_q.size()), 64'(1));
        end else begin
          e = sb_q.pop_front();
          chk("so", 64'(so), 64'(e.s));
          chk("c_out", 64'(c_out), 64'(e.c));
          chk("ovf_out", 64'(ovf_out), 64'(e.ovf));
`ifdef BIG_ADDER_CARRY_VEC_EN
          chk("carry_vec", 64'(carry_vec), 64'(e.cv));
          chk("carry_vec_msb", 64'(carry_vec[W-1]), 64'(c_out));
`endif
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(a_in, b_in, sub_in, c_in));
      prev_stall = out_valid && !out_ready;
      prev_so    = so;
    end
  end

  // Drives from posedge+1; returns at posedge+1 right after the beat was accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic ci);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; a_in = a; b_in = b; sub_in = s; c_in = ci;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(trunc($urandom), trunc($urandom), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
  endtask

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int           n;
    bit           rnd_on;
    logic [W-1:0] maxu, maxp, minn, one_w;
    maxu  = '1;
    maxp  = {1'b0, {(W-1){1'b1}}};
    minn  = {1'b1, {(W-1){1'b0}}};
    one_w = W'(1);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_so", 64'(so), 64'(0));
    chk("rst_c_out", 64'(c_out), 64'(0));
    chk("rst_ovf", 64'(ovf_out), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Latency on an empty pipe
    send(trunc(32'hF0F0), trunc(32'h0F0F), 1'b0, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", 64'(n), 64'(NS));
    drain();

    // Adds, boundaries, subtracts
    send(trunc(32'hE2A1), trunc(32'h1234), 1'b0, 1'b0);
    send(trunc(32'h1234), trunc(32'h8765), 1'b0, 1'b0);
    send(maxu, one_w, 1'b0, 1'b0);
    send(maxp, one_w, 1'b0, 1'b0);
    send('0, '0, 1'b0, 1'b1);
    send(trunc(32'h1234), trunc(32'h8765), 1'b1, 1'b0);
    send(minn, one_w, 1'b1, 1'b1);
    send(maxu, maxu, 1'b0, 1'b1);
    drain();

    // Backpressure: 8 back-to-back beats, consumer stalls 3 cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (NS + 2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random consumer readiness
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end else begin
            send_rand();
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a beat held at the output
    out_ready = 1'b0;
    send(trunc(32'h5A5A), trunc(32'h0101), 1'b0, 1'b0);
    repeat (NS + 1) @(posedge clk);
    #1 chk("pre_rst_valid", 64'(out_valid), 64'(1));
    #3 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_so", 64'(so), 64'(0));
    chk("midrst_c_out", 64'(c_out), 64'(0));
    chk("midrst_ovf", 64'(ovf_out), 64'(0));
`ifdef BIG_ADDER_CARRY_VEC_EN
    chk("midrst_carry_vec", 64'(carry_vec), 64'(0));
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(maxu, one_w, 1'b0, 1'b0);
    send(trunc(32'h1234), trunc(32'h8765), 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
